// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, functs, ALU operation encoding and control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu,
        AluSll, AluSrl, AluSra, AluLui, AluPass
    } alu_op_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch_eq;
        logic branch_ne;
        logic jump;
        logic link;
        logic illegal;
    } ctrl_t;

    typedef enum logic [1:0] {DstNone, DstRd, DstRt, DstRa} dst_sel_t;
    typedef enum logic [1:0] {ImmSign, ImmZero, ImmLui} imm_mode_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational main decoder: opcode/funct to ALU op, control bits, destination and immediate mode.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_t    aluOp,
    output ctrl_t      ctrl,
    output dst_sel_t   dstSel,
    output imm_mode_t  immMode,
    output logic       usesRs,
    output logic       usesRt
);

    always_comb begin
        aluOp        = AluPass;
        ctrl         = '0;
        ctrl.illegal = 1'b1;
        dstSel       = DstNone;
        immMode      = ImmSign;
        usesRs       = 1'b0;
        usesRt       = 1'b0;

        unique case (opcode)
            OP_RTYPE: begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                dstSel         = DstRd;
                usesRs         = 1'b1;
                usesRt         = 1'b1;
                unique case (funct)
                    FN_ADD, FN_ADDU: aluOp = AluAdd;
                    FN_SUB, FN_SUBU: aluOp = AluSub;
                    FN_AND:          aluOp = AluAnd;
                    FN_OR:           aluOp = AluOr;
                    FN_XOR:          aluOp = AluXor;
                    FN_NOR:          aluOp = AluNor;
                    FN_SLT:          aluOp = AluSlt;
                    FN_SLTU:         aluOp = AluSltu;
                    // Constant shifts take their amount from shamt, never from rs.
                    FN_SLL: begin aluOp = AluSll; usesRs = 1'b0; end
                    FN_SRL: begin aluOp = AluSrl; usesRs = 1'b0; end
                    FN_SRA: begin aluOp = AluSra; usesRs = 1'b0; end
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.jump      = 1'b1;
                        dstSel         = DstNone;
                    end
                    default: begin
                        ctrl.illegal   = 1'b1;
                        ctrl.reg_write = 1'b0;
                        dstSel         = DstNone;
                        usesRs         = 1'b0;
                        usesRt         = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                dstSel         = DstRt;
                usesRs         = (opcode != OP_LUI);
                unique case (opcode)
                    OP_SLTI:  aluOp = AluSlt;
                    OP_SLTIU: aluOp = AluSltu;
                    OP_ANDI:  begin aluOp = AluAnd; immMode = ImmZero; end
                    OP_ORI:   begin aluOp = AluOr;  immMode = ImmZero; end
                    OP_XORI:  begin aluOp = AluXor; immMode = ImmZero; end
                    OP_LUI:   begin aluOp = AluLui; immMode = ImmLui;  end
                    default:  aluOp = AluAdd;
                endcase
            end
            OP_LW: begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                aluOp          = AluAdd;
                dstSel         = DstRt;
                usesRs         = 1'b1;
            end
            OP_SW: begin
                ctrl.illegal   = 1'b0;
                ctrl.mem_write = 1'b1;
                aluOp          = AluAdd;
                usesRs         = 1'b1;
                usesRt         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.illegal   = 1'b0;
                ctrl.branch_eq = (opcode == OP_BEQ);
                ctrl.branch_ne = (opcode == OP_BNE);
                aluOp          = AluSub;
                usesRs         = 1'b1;
                usesRt         = 1'b1;
            end
            OP_J: begin
                ctrl.illegal = 1'b0;
                ctrl.jump    = 1'b1;
            end
            OP_JAL: begin
                ctrl.illegal   = 1'b0;
                ctrl.jump      = 1'b1;
                ctrl.link      = 1'b1;
                ctrl.reg_write = 1'b1;
                dstSel         = DstRa;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_decode_stage.sv
// MIPS ID stage: register-file read with writeback bypass, load-use stall and the ID/EX register.
module mips_decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [RA_W-1:0] rf_rs_addr,
    output logic [RA_W-1:0] rf_rt_addr,
    input  logic [XLEN-1:0] rf_rs_data,
    input  logic [XLEN-1:0] rf_rt_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs_val,
    output logic [XLEN-1:0] ex_rt_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_shamt,
    output logic [RA_W-1:0] ex_dst,
    output logic [3:0]      ex_alu_op,
    output logic [7:0]      ex_ctrl
);

    logic [RA_W-1:0] rsAddr, rtAddr, rdAddr, dst;
    logic [XLEN-1:0] rsVal, rtVal, imm;
    alu_op_t         aluOp;
    ctrl_t           ctrl;
    dst_sel_t        dstSel;
    imm_mode_t       immMode;
    logic            usesRs, usesRt, hazard, exLoad, exValidD;

    logic            exValidQ;
    logic [XLEN-1:0] exPcQ, exRsValQ, exRtValQ, exImmQ;
    logic [4:0]      exShamtQ;
    logic [RA_W-1:0] exDstQ;
    alu_op_t         exAluOpQ;
    ctrl_t           exCtrlQ;

    assign rsAddr     = RA_W'(if_instr[25:21]);
    assign rtAddr     = RA_W'(if_instr[20:16]);
    assign rdAddr     = RA_W'(if_instr[15:11]);
    assign rf_rs_addr = rsAddr;
    assign rf_rt_addr = rtAddr;

    mips_ctrl_decode uCtrlDecode (
        .opcode  (if_instr[31:26]),
        .funct   (if_instr[5:0]),
        .aluOp   (aluOp),
        .ctrl    (ctrl),
        .dstSel  (dstSel),
        .immMode (immMode),
        .usesRs  (usesRs),
        .usesRt  (usesRt)
    );

    // A write landing this cycle is not yet visible in the regfile read data.
    always_comb begin
        rsVal = rf_rs_data;
        if (rsAddr == '0) begin
            rsVal = '0;
        end else if (wb_we && (wb_addr == rsAddr)) begin
            rsVal = wb_data;
        end
        rtVal = rf_rt_data;
        if (rtAddr == '0) begin
            rtVal = '0;
        end else if (wb_we && (wb_addr == rtAddr)) begin
            rtVal = wb_data;
        end
    end

    always_comb begin
        unique case (immMode)
            ImmZero: imm = {{(XLEN-16){1'b0}}, if_instr[15:0]};
            ImmLui:  imm = {if_instr[15:0], {(XLEN-16){1'b0}}};
            default: imm = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
        endcase
        unique case (dstSel)
            DstRd:   dst = rdAddr;
            DstRt:   dst = rtAddr;
            DstRa:   dst = RA_W'(REG_RA);
            default: dst = '0;
        endcase
    end

    assign hazard = exValidQ && exCtrlQ.mem_read && (exDstQ != '0) &&
                    (((exDstQ == rsAddr) && usesRs) || ((exDstQ == rtAddr) && usesRt));
    assign id_ready = flush || (!hazard && (!exValidQ || ex_ready));

    always_comb begin
        exLoad   = 1'b0;
        exValidD = exValidQ;
        if (flush) begin
            exValidD = 1'b0;
        end else if (if_valid && id_ready) begin
            exLoad   = 1'b1;
            exValidD = 1'b1;
        end else if (ex_ready && (hazard || !if_valid)) begin
            exValidD = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exValidQ <= 1'b0;
            exPcQ    <= '0;
            exRsValQ <= '0;
            exRtValQ <= '0;
            exImmQ   <= '0;
            exShamtQ <= '0;
            exDstQ   <= '0;
            exAluOpQ <= AluAdd;
            exCtrlQ  <= '0;
        end else begin
            exValidQ <= exValidD;
            if (exLoad) begin
                exPcQ    <= if_pc;
                exRsValQ <= rsVal;
                exRtValQ <= rtVal;
                exImmQ   <= imm;
                exShamtQ <= if_instr[10:6];
                exDstQ   <= dst;
                exAluOpQ <= aluOp;
                exCtrlQ  <= ctrl;
            end
        end
    end

    assign ex_valid  = exValidQ;
    assign ex_pc     = exPcQ;
    assign ex_rs_val = exRsValQ;
    assign ex_rt_val = exRtValQ;
    assign ex_imm    = exImmQ;
    assign ex_shamt  = exShamtQ;
    assign ex_dst    = exDstQ;
    assign ex_alu_op = exAluOpQ;
    assign ex_ctrl   = exCtrlQ;

endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- ID stage of the pipelined MIPS core, sitting directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and decodes them.
- Drives the two register-file read addresses and captures the returned operands, with writeback bypass.
- Detects load-use hazards and holds the ID/EX pipeline register that feeds EX.

Parameters:
- XLEN, 32, datapath width (instruction, PC, operands).
- RA_W, 5, register address width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  XLEN  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- id_ready  out  1  stage accepts if_instr this cycle.
- rf_rs_addr  out  RA_W  regfile readReg1 (instr[25:21]).
- rf_rt_addr  out  RA_W  regfile readReg2 (instr[20:16]).
- rf_rs_data  in  XLEN  regfile readData1 (combinational).
- rf_rt_data  in  XLEN  regfile readData2 (combinational).
- wb_we  in  1  writeback write enable.
- wb_addr  in  RA_W  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  branch/jump redirect; kill ID and ID/EX contents.
- ex_ready  in  1  EX accepts the ID/EX register.
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_pc  out  XLEN  PC.
- ex_rs_val  out  XLEN  rs operand.
- ex_rt_val  out  XLEN  rt operand.
- ex_imm  out  XLEN  extended immediate.
- ex_shamt  out  5  shift amount.
- ex_dst  out  RA_W  destination register.
- ex_alu_op  out  4  alu_op_t.
- ex_ctrl  out  8  {reg_write, mem_read, mem_write, branch_eq, branch_ne, jump, link, illegal}.

Behaviour:
- Reset (async, reset_n=0): all ex_* outputs cleared to 0, including ex_valid=0. Reset mid-transfer discards the instruction.
- Read addresses are driven combinationally from if_instr regardless of if_valid.
- Bypass: if wb_we and wb_addr == source address and the address is nonzero, the operand is wb_data, otherwise the regfile data. $zero always reads 0.
- Destination register:
  - R-type: rd.
  - I-type ALU and lw: rt.
  - jal: 31.
  - sw, beq, bne, j, jr: 0, with reg_write=0.
- Immediate:
  - andi/ori/xori: zero-extended.
  - lui: imm<<16.
  - All others: sign-extended.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other encoding: illegal=1, reg_write=mem_read=mem_write=0, ex_valid still asserted so EX can trap.
- Load-use hazard: hazard = ex_valid & ex_ctrl.mem_read & ex_dst≠0 & ((ex_dst==rs & uses_rs) | (ex_dst==rt & uses_rt)).
  - uses_rt is 1 for R-type, sw, beq and bne.
- id_ready = flush | (!hazard & (!ex_valid | ex_ready)).
- Register update priority, evaluated per rising edge:
  1. flush: ex_valid←0. Any if_instr presented is consumed and dropped.
  2. if_valid & id_ready: load ID/EX with decoded fields, ex_valid←1. One-cycle latency.
  3. hazard & ex_ready: insert bubble, ex_valid←0, other fields don't-care.
  4. ex_ready & !if_valid: ex_valid←0.
  5. Otherwise hold all ex_* stable.
- ex_* outputs must not change while ex_valid & !ex_ready.
- Hazard stalls exactly one cycle after the load leaves. Forwarding from MEM/WB is EX's responsibility.

Decomposition:
- mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI…OP_LUI);
  - funct constants;
  - alu_op_t enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, PASS);
  - the ctrl_t packed struct;
  - REG_RA = 31.
- Sub-module mips_ctrl_decode: purely combinational instr→{alu_op, ctrl, dst select, imm mode, uses_rs, uses_rt}. The stage itself owns the bypass, hazard logic and ID/EX register.

Test Plan:
- Reset released, instr 0x012A4020 (add $8,$9,$10), with $9=5, $10=7 from regfile → next cycle ex_valid=1, rs_val=5, rt_val=7, dst=8, alu_op=ADD, reg_write=1.
- Writeback bypass: same cycle wb_we=1, wb_addr=9, wb_data=0x11 → ex_rs_val=0x11. With wb_addr=0, wb_data=0x11 and rs=$0 → ex_rs_val=0.
- Load-use: lw $8,4($9) accepted, then add $10,$8,$8 with ex_ready=1 → id_ready=0 for one cycle, one bubble (ex_valid=0), then add captured.
- Backpressure: ex_ready=0 for 3 cycles → ex_* held constant, id_ready=0. ex_ready=1 → next instruction accepted.
- Flush with a valid ID/EX entry and if_valid=1 → next cycle ex_valid=0 and the instruction is dropped. reset_n pulsed mid-stall → ex_valid=0 asynchronously.
- Immediates and illegal opcode: ori imm 0xFFFF → ex_imm=0x0000FFFF; addi imm 0xFFFF → 0xFFFFFFFF; lui 0x1234 → 0x12340000; opcode 0x3F → illegal=1, reg_write=0.
